// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared constants for the VGA tile renderer: default 640x480@60 timing
//   (pixel counts per region), counter width and display-mode encodings.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // wide enough for h 0..799 and v 0..524
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BARS  = 2'd3
    } vga_mode_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-tick divider plus horizontal/vertical scan counters and raw
//   (undelayed) sync / active-area flags.
// Ports
//   clk_100MHz, reset_n : system clock, async active-low reset
//   p_tick              : one clk high out of every CLK_DIV
//   h_cnt, v_cnt        : current scan position
//   h_end, v_end        : position is the last column / last line
//   frame_sof           : p_tick while at h=0, v=0
//   hsync_raw, vsync_raw: active-low syncs for the current position
//   video_on            : current position is inside the active area
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    output logic             p_tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_end,
    output logic             v_end,
    output logic             frame_sof,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             video_on
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_STOP  = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_STOP  = VS_START + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (p_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_end  = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_end  = (v_cnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign frame_sof = p_tick && (h_cnt == '0) && (v_cnt == '0);
    assign hsync_raw = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_STOP)));
    assign vsync_raw = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_STOP)));
    assign video_on  = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
//   VGA front end: scan timing, screen-to-tile mapping, framebuffer fetch
//   from an external synchronous RAM, test patterns, registered pixel/sync
//   outputs with a fixed 2 pixel-tick latency.
// Ports
//   clk_100MHz, reset_n : system clock, async active-low reset
//   mode                : 0 framebuffer, 1 solid, 2 tile checker, 3 bars
//   solid_color         : {r,g,b} used by solid and checker modes
//   mem_en, mem_addr    : RAM read request (one tile address per pixel)
//   mem_dout            : RAM read data {r,g,b}
//   hsync, vsync        : active-low syncs, aligned with the pixel outputs
//   red, green, blue    : pixel colour, zero during blanking
//   frame_start         : one clk pulse at the p_tick where h=0, v=0
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int TILE_W   = 10,
    parameter int TILE_H   = 15,
    parameter int TX_LOG2  = 6,
    parameter int ADDR_W   = 11,
    parameter int MEM_LAT  = 1,
    parameter int COLOR_W  = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_n,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_color,
    output logic                 mem_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [3*COLOR_W-1:0] mem_dout,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 frame_start
);

    localparam int RGB_W  = 3 * COLOR_W;
    localparam int PX_W   = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int LN_W   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int TY_W   = ADDR_W - TX_LOG2;
    localparam int BAR_PX = H_ACTIVE / 8;

    // The colour is captured one full pixel tick after the address, so the
    // RAM must answer within CLK_DIV-1 clocks.
    if ((MEM_LAT < 1) || (MEM_LAT > CLK_DIV - 1)) begin : g_bad_mem_lat
        $error("MEM_LAT must be in 1..CLK_DIV-1");
    end

    logic             p_tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_end;
    logic             v_end;
    logic             frame_sof;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             video_on;

    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk_100MHz(clk_100MHz),
        .reset_n   (reset_n),
        .p_tick    (p_tick),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .h_end     (h_end),
        .v_end     (v_end),
        .frame_sof (frame_sof),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .video_on  (video_on)
    );

    // Tile counters track the current h/v position incrementally so the
    // address path needs no divider. tx holds after the last active column;
    // ty may run on during vertical blanking and is cleared at v=0.
    logic [PX_W-1:0]    px;
    logic [TX_LOG2-1:0] tx;
    logic [LN_W-1:0]    ln;
    logic [TY_W-1:0]    ty;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            px <= '0;
            tx <= '0;
            ln <= '0;
            ty <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                px <= '0;
                tx <= '0;
                if (v_end) begin
                    ln <= '0;
                    ty <= '0;
                end else if (ln == LN_W'(TILE_H - 1)) begin
                    ln <= '0;
                    ty <= ty + 1'b1;
                end else begin
                    ln <= ln + 1'b1;
                end
            end else if (h_cnt < CNT_W'(H_ACTIVE - 1)) begin
                if (px == PX_W'(TILE_W - 1)) begin
                    px <= '0;
                    tx <= tx + 1'b1;
                end else begin
                    px <= px + 1'b1;
                end
            end
        end
    end

    logic [ADDR_W-1:0] tile_addr;
    assign tile_addr = (ADDR_W'(ty) << TX_LOG2) + ADDR_W'(tx);

    // Stage 1: address issue plus everything stage 2 needs for this pixel.
    logic             video_on_q;
    logic             hsync_q;
    logic             vsync_q;
    logic [CNT_W-1:0] h_q;
    logic             chk_q;
    vga_mode_t        mode_q;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr   <= '0;
            video_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            h_q        <= '0;
            chk_q      <= 1'b0;
            mode_q     <= MODE_FB;
        end else if (p_tick) begin
            mem_addr   <= tile_addr;
            video_on_q <= video_on;
            hsync_q    <= hsync_raw;
            vsync_q    <= vsync_raw;
            h_q        <= h_cnt;
            chk_q      <= tx[0] ^ ty[0];
            // mode only changes on a frame boundary to avoid tearing
            if (frame_sof) begin
                mode_q <= vga_mode_t'(mode);
            end
        end
    end

    assign mem_en      = video_on_q;
    assign frame_start = frame_sof;

    logic [2:0]       bar_idx;
    logic [RGB_W-1:0] pix_next;

    assign bar_idx = 3'(h_q / CNT_W'(BAR_PX));

    always_comb begin
        pix_next = '0;
        case (mode_q)
            MODE_FB:    pix_next = mem_dout;
            MODE_SOLID: pix_next = solid_color;
            MODE_CHECK: pix_next = chk_q ? solid_color : ~solid_color;
            MODE_BARS:  pix_next = {{COLOR_W{bar_idx[2]}},
                                    {COLOR_W{bar_idx[1]}},
                                    {COLOR_W{bar_idx[0]}}};
            default:    pix_next = '0;
        endcase
        if (!video_on_q) begin
            pix_next = '0;
        end
    end

    // Stage 2: pixel and syncs leave together.
    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (p_tick) begin
            rgb_q <= pix_next;
            hsync <= hsync_q;
            vsync <= vsync_q;
        end
    end

    assign red   = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign green = rgb_q[2*COLOR_W-1:COLOR_W];
    assign blue  = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;

    localparam int CLK_DIV = 4;
    localparam int TILE_W  = 10;
    localparam int TILE_H  = 15;
    localparam int TX_LOG2 = 6;
    localparam int ADDR_W  = 11;
    localparam int COLOR_W = 4;

    // reduced screen geometry for the main instance
    localparam int HA = 40, HF = 2, HS = 4, HB = 2;
    localparam int VA = 30, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk_100MHz = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [11:0] solid_color;
    logic [11:0] mem_dout = 12'h000;
    logic        mem_en;
    logic [10:0] mem_addr;
    logic        hsync, vsync, frame_start;
    logic [3:0]  red, green, blue;

    logic [1:0]  dd_mode = 2'd0;
    logic [11:0] dd_solid = 12'h000;
    logic [11:0] dd_mem_dout = 12'h000;
    logic        dd_mem_en;
    logic [10:0] dd_mem_addr;
    logic        dd_hsync, dd_vsync, dd_frame_start;
    logic [3:0]  dd_red, dd_green, dd_blue;

    logic [11:0] ram [0:2047];
    logic [1:0]  fmode [0:3];

    int total = 0;
    int bad = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    always @(posedge clk_100MHz) begin
        if (mem_en) mem_dout <= ram[mem_addr];
    end

    vga_tile_renderer #(
        .CLK_DIV(CLK_DIV), .TILE_W(TILE_W), .TILE_H(TILE_H), .TX_LOG2(TX_LOG2),
        .ADDR_W(ADDR_W), .MEM_LAT(1), .COLOR_W(COLOR_W),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .mode(mode),
        .solid_color(solid_color), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .hsync(hsync), .vsync(vsync), .red(red),
        .green(green), .blue(blue), .frame_start(frame_start)
    );

    vga_tile_renderer dut_def (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n), .mode(dd_mode),
        .solid_color(dd_solid), .mem_en(dd_mem_en), .mem_addr(dd_mem_addr),
        .mem_dout(dd_mem_dout), .hsync(dd_hsync), .vsync(dd_vsync), .red(dd_red),
        .green(dd_green), .blue(dd_blue), .frame_start(dd_frame_start)
    );

    function automatic logic pick(input int sel);
        case (sel)
            0:       return dd_hsync;
            1:       return hsync;
            default: return vsync;
        endcase
    endfunction

    // Reference pixel colour from screen position and frame mode.
    function automatic logic [11:0] ref_pixel(input int hh, input int vv,
                                              input logic [1:0] m, input logic [11:0] sol);
        int txi, tyi;
        logic [2:0] b;
        if (!(hh < HA && vv < VA)) return 12'h000;
        txi = hh / TILE_W;
        tyi = vv / TILE_H;
        case (m)
            2'd0: return ram[tyi * (1 << TX_LOG2) + txi];
            2'd1: return sol;
            2'd2: return (((txi + tyi) % 2) == 1) ? sol : ~sol;
            default: begin
                b = 3'(hh / (HA / 8));
                return {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
            end
        endcase
    endfunction

    task automatic measure(input int sel, input int limit,
                           output int period, output int low_len, output bit ok);
        logic prev, cur;
        int f1, r1, f2;
        f1 = -1; r1 = -1; f2 = -1;
        @(negedge clk_100MHz);
        prev = pick(sel);
        for (int n = 1; n <= limit && f2 < 0; n++) begin
            @(negedge clk_100MHz);
            cur = pick(sel);
            if (prev && !cur) begin
                if (f1 < 0) f1 = n;
                else f2 = n;
            end
            if (!prev && cur && f1 >= 0 && r1 < 0) r1 = n;
            prev = cur;
        end
        ok = (f1 >= 0) && (r1 >= 0) && (f2 >= 0);
        period = f2 - f1;
        low_len = r1 - f1;
    endtask

    task automatic test_reset;
        int n;
        bit found;
        reset_n = 1'b0;
        mode = 2'd0;
        solid_color = 12'h000;
        repeat (10) @(negedge clk_100MHz);
        total++; if (hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        total++; if (vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", vsync); end
        total++; if ({red, green, blue} !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", {red, green, blue}); end
        total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        total++; if (mem_addr !== 11'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
        total++; if ({dd_hsync, dd_vsync, dd_mem_en, dd_red, dd_green, dd_blue} !== {3'b110, 12'h000})
            begin bad++; $display("FAIL reset_default_inst got=%b exp=110000000000000", {dd_hsync, dd_vsync, dd_mem_en, dd_red, dd_green, dd_blue}); end
        reset_n = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 8 && !found; i++) begin
            @(negedge clk_100MHz);
            if (frame_start) begin found = 1'b1; n = i; end
        end
        total++; if (!found || n > 4) begin bad++; $display("FAIL reset_first_frame_start got=%0d clk exp<=4", found ? n : -1); end
    endtask

    task automatic test_line_timing;
        int per, low;
        bit ok;
        measure(0, 8000, per, low, ok);
        total++; if (!ok || per != 800 * CLK_DIV) begin bad++; $display("FAIL hsync_period_default got=%0d exp=%0d ok=%0d", per, 800 * CLK_DIV, ok); end
        total++; if (!ok || low != 96 * CLK_DIV) begin bad++; $display("FAIL hsync_low_default got=%0d exp=%0d ok=%0d", low, 96 * CLK_DIV, ok); end
        measure(1, 1000, per, low, ok);
        total++; if (!ok || per != HT * CLK_DIV) begin bad++; $display("FAIL hsync_period got=%0d exp=%0d ok=%0d", per, HT * CLK_DIV, ok); end
        total++; if (!ok || low != HS * CLK_DIV) begin bad++; $display("FAIL hsync_low got=%0d exp=%0d ok=%0d", low, HS * CLK_DIV, ok); end
    endtask

    task automatic test_frame_timing;
        int per, low;
        bit ok;
        measure(2, 16000, per, low, ok);
        total++; if (!ok || per != FRAME * CLK_DIV) begin bad++; $display("FAIL vsync_period got=%0d exp=%0d ok=%0d", per, FRAME * CLK_DIV, ok); end
        total++; if (!ok || low != VS * HT * CLK_DIV) begin bad++; $display("FAIL vsync_low got=%0d exp=%0d ok=%0d", low, VS * HT * CLK_DIV, ok); end
    endtask

    // Scans whole frames from a frame_start, checking every clk of every
    // pixel tick. sw_at (pixel index, <0 for none) changes the inputs mid-run.
    task automatic run_frames(input int nframes, input int sw_at,
                              input logic [1:0] sw_mode, input logic [11:0] sw_solid);
        int c, p, f, h, v, q, qp, qh, qv;
        bit act;
        logic [10:0] ea;
        logic [11:0] er;
        logic es;
        c = 0;
        @(negedge clk_100MHz);
        while (!frame_start && c < 2 * FRAME * CLK_DIV) begin
            @(negedge clk_100MHz);
            c++;
        end
        total++;
        if (!frame_start) begin bad++; $display("FAIL frame_start_timeout got=0 exp=1"); return; end
        for (int j = 0; j < nframes * FRAME; j++) begin
            for (int o = 0; o < CLK_DIV; o++) begin
                if (!(j == 0 && o == 0)) @(negedge clk_100MHz);
                p = j % FRAME;
                f = j / FRAME;
                if (o == 0 && p == 0) fmode[f] = mode;
                es = (o == 0 && p == 0);
                total++; if (frame_start !== es) begin bad++; $display("FAIL frame_start pix=%0d clk=%0d got=%b exp=%b", j, o, frame_start, es); end
                if (o == 2) begin
                    h = p % HT;
                    v = p / HT;
                    act = (h < HA) && (v < VA);
                    total++; if (mem_en !== act) begin bad++; $display("FAIL mem_en h=%0d v=%0d got=%b exp=%b", h, v, mem_en, act); end
                    if (act) begin
                        ea = 11'((v / TILE_H) * (1 << TX_LOG2) + h / TILE_W);
                        total++; if (mem_addr !== ea) begin bad++; $display("FAIL mem_addr h=%0d v=%0d got=%0d exp=%0d", h, v, mem_addr, ea); end
                    end
                    if (j > 0) begin
                        q  = j - 1;
                        qp = q % FRAME;
                        qh = qp % HT;
                        qv = qp / HT;
                        er = ref_pixel(qh, qv, fmode[q / FRAME], solid_color);
                        total++; if ({red, green, blue} !== er) begin bad++; $display("FAIL rgb h=%0d v=%0d mode=%0d got=%h exp=%h", qh, qv, fmode[q / FRAME], {red, green, blue}, er); end
                        es = !((qh >= HA + HF) && (qh < HA + HF + HS));
                        total++; if (hsync !== es) begin bad++; $display("FAIL hsync h=%0d v=%0d got=%b exp=%b", qh, qv, hsync, es); end
                        es = !((qv >= VA + VF) && (qv < VA + VF + VS));
                        total++; if (vsync !== es) begin bad++; $display("FAIL vsync h=%0d v=%0d got=%b exp=%b", qh, qv, vsync, es); end
                    end
                    if (j == sw_at) begin
                        mode = sw_mode;
                        if (fmode[f] == 2'd0 || fmode[f] == 2'd3) solid_color = sw_solid;
                    end
                end
            end
        end
    endtask

    task automatic test_framebuffer;
        mode = 2'd0;
        run_frames(1, -1, 2'd0, 12'h000);
    endtask

    task automatic test_mode_switch;
        // switch requested at line 10 of a framebuffer frame
        run_frames(2, 10 * HT, 2'd1, 12'hF00);
    endtask

    task automatic test_patterns;
        mode = 2'd2;
        solid_color = 12'($urandom);
        run_frames(2, (VA / 2) * HT + 7, 2'd3, solid_color);
    endtask

    task automatic test_random_modes;
        for (int i = 0; i < 2; i++) begin
            mode = 2'($urandom_range(0, 3));
            solid_color = 12'($urandom);
            run_frames(1, -1, 2'd0, 12'h000);
        end
    endtask

    task automatic test_reset_midframe;
        int c, n;
        bit found;
        c = 0;
        while (hsync !== 1'b0 && c < 1000) begin
            @(negedge clk_100MHz);
            c++;
        end
        total++; if (hsync !== 1'b0) begin bad++; $display("FAIL midframe_hsync_wait got=%b exp=0", hsync); end
        reset_n = 1'b0;
        #1;
        total++; if ({hsync, vsync} !== 2'b11) begin bad++; $display("FAIL midframe_syncs got=%b exp=11", {hsync, vsync}); end
        total++; if ({mem_en, mem_addr, red, green, blue, frame_start} !== 25'd0)
            begin bad++; $display("FAIL midframe_outputs got=%h exp=0", {mem_en, mem_addr, red, green, blue, frame_start}); end
        repeat (5) @(negedge clk_100MHz);
        reset_n = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 8 && !found; i++) begin
            @(negedge clk_100MHz);
            if (frame_start) begin found = 1'b1; n = i; end
        end
        total++; if (!found || n > 4) begin bad++; $display("FAIL midframe_frame_start got=%0d clk exp<=4", found ? n : -1); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 12'($urandom);
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_framebuffer();
        test_mode_switch();
        test_patterns();
        test_random_modes();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
